// File: rtl/encode325_req.sv
// 32-to-5 request encoder: sticky pending vector drained one index at a time over valid/ready.
// Fixed-priority or round-robin selection, registered outputs, duplicate-request pulse.
module encode325_req #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] req_in,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [4:0]  out_index,
    output logic [31:0] pending,
    output logic        dup_pulse
);

    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    logic [31:0] pending_q;
    logic        valid_q;
    logic [4:0]  index_q;
    logic        dup_q;

    logic        xfer;
    logic [31:0] clr_mask;
    logic [31:0] pending_d;
    logic        dup_d;
    logic [4:0]  enc_d;

    assign xfer     = valid_q & out_ready;
    assign clr_mask = xfer ? (32'd1 << index_q) : 32'd0;

    // A set arriving on the acknowledged bit wins over the clear.
    assign pending_d = flush ? req_in : ((pending_q & ~clr_mask) | req_in);
    assign dup_d     = (|(req_in & pending_q & ~clr_mask)) & ~flush;

    generate
        if (ROUND_ROBIN) begin : g_rr
            logic [4:0]  last_grant_q;
            logic [4:0]  grant_base;
            logic [4:0]  search_start;
            logic [31:0] upper_mask;
            logic [31:0] upper_bits;

            // The grant made this cycle already steers the next search.
            assign grant_base   = xfer ? index_q : last_grant_q;
            assign search_start = grant_base + 5'd1;
            assign upper_mask   = 32'hFFFF_FFFF << search_start;
            assign upper_bits   = pending_d & upper_mask;
            assign enc_d        = (|upper_bits) ? lowest_set(upper_bits) : lowest_set(pending_d);

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    last_grant_q <= 5'd31;
                end else if (xfer) begin
                    last_grant_q <= index_q;
                end
            end
        end else begin : g_fixed
            assign enc_d = lowest_set(pending_d);
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= 32'd0;
            valid_q   <= 1'b0;
            index_q   <= 5'd0;
            dup_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= |pending_d;
            if (|pending_d) begin
                index_q <= enc_d;
            end
            dup_q     <= dup_d;
        end
    end

    assign out_valid = valid_q;
    assign out_index = index_q;
    assign pending   = pending_q;
    assign dup_pulse = dup_q;

endmodule

// File: tb/tb_encode325_req.sv
// Scoreboard bench: fixed-priority and round-robin instances driven with the same stimulus,
// each checked against a per-cycle behavioural model of the pending set.
module tb_encode325_req;

    logic        clock;
    logic        reset;
    logic [31:0] req_in;
    logic        flush;
    logic        out_ready;

    logic        v0, v1;
    logic [4:0]  i0, i1;
    logic [31:0] p0, p1;
    logic        d0, d1;

    encode325_req #(.ROUND_ROBIN(1'b0)) dut_fixed (
        .clock(clock), .reset(reset), .req_in(req_in), .flush(flush), .out_ready(out_ready),
        .out_valid(v0), .out_index(i0), .pending(p0), .dup_pulse(d0)
    );

    encode325_req #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clock(clock), .reset(reset), .req_in(req_in), .flush(flush), .out_ready(out_ready),
        .out_valid(v1), .out_index(i1), .pending(p1), .dup_pulse(d1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        v;
        logic [4:0]  idx;
        logic [31:0] pend;
        logic        dup;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: the set of pending requests plus the visible outputs.
    bit          m_set [2][32];
    bit          m_valid [2];
    int          m_idx [2];
    int          m_lg [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input int r, input logic [31:0] req, input logic fl,
                              input logic rdy, input logic rs);
        exp_t e;
        bit   xfer;
        bit   dup;
        bit   nxt [32];
        int   cnt;
        if (rs) begin
            for (int i = 0; i < 32; i++) m_set[r][i] = 1'b0;
            m_valid[r] = 1'b0;
            m_idx[r]   = 0;
            m_lg[r]    = 31;
            dup        = 1'b0;
        end else begin
            xfer = m_valid[r] && rdy;
            dup  = 1'b0;
            for (int i = 0; i < 32; i++) begin
                bit old_kept;
                old_kept = m_set[r][i] && !(xfer && i == m_idx[r]);
                if (req[i] && old_kept && !fl) dup = 1'b1;
                nxt[i] = fl ? req[i] : (old_kept || req[i]);
            end
            if (xfer) m_lg[r] = m_idx[r];
            cnt = 0;
            for (int i = 0; i < 32; i++) begin
                m_set[r][i] = nxt[i];
                if (nxt[i]) cnt++;
            end
            if (cnt == 0) begin
                m_valid[r] = 1'b0;
            end else begin
                m_valid[r] = 1'b1;
                for (int k = 31; k >= 0; k--) begin
                    int cand;
                    cand = (r == 1) ? (m_lg[r] + 1 + k) % 32 : k;
                    if (nxt[cand]) m_idx[r] = cand;
                end
            end
        end
        e.v   = m_valid[r];
        e.idx = 5'(m_idx[r]);
        for (int i = 0; i < 32; i++) e.pend[i] = m_set[r][i];
        e.dup = dup;
        if (r == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic step(input logic [31:0] r, input logic f, input logic rd, input logic rs = 1'b0);
        @(posedge clock);
        #2;
        req_in    = r;
        flush     = f;
        out_ready = rd;
        reset     = ~rs;
        model_step(0, r, f, rd, rs);
        model_step(1, r, f, rd, rs);
        $display("cycle t=%0t req=%08h flush=%0b ready=%0b rst=%0b -> fixed v=%0b idx=%0d | rr v=%0b idx=%0d",
                 $time, r, f, rd, rs, m_valid[0], m_idx[0], m_valid[1], m_idx[1]);
    endtask

    // Monitor: whatever the DUTs present after each edge is compared with the oldest expectation.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q0.size() > 0) begin
                exp_t e;
                e = exp_q0.pop_front();
                check("fixed out_valid", 32'(v0), 32'(e.v));
                check("fixed out_index", 32'(i0), 32'(e.idx));
                check("fixed pending",   p0, e.pend);
                check("fixed dup_pulse", 32'(d0), 32'(e.dup));
            end
            if (exp_q1.size() > 0) begin
                exp_t e;
                e = exp_q1.pop_front();
                check("rr out_valid", 32'(v1), 32'(e.v));
                check("rr out_index", 32'(i1), 32'(e.idx));
                check("rr pending",   p1, e.pend);
                check("rr dup_pulse", 32'(d1), 32'(e.dup));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_in    = 32'hFFFF_FFFF;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 32; i++) m_set[r][i] = 1'b0;
            m_valid[r] = 1'b0;
            m_idx[r]   = 0;
            m_lg[r]    = 31;
        end

        // Requests during reset must be ignored.
        repeat (3) begin
            @(posedge clock);
            #1;
            check("reset fixed out_valid", 32'(v0), 32'd0);
            check("reset fixed pending",   p0, 32'd0);
            check("reset fixed dup_pulse", 32'(d0), 32'd0);
            check("reset rr out_valid",    32'(v1), 32'd0);
            check("reset rr pending",      p1, 32'd0);
        end

        step(32'h0, 1'b0, 1'b0);

        // Single request held, then accepted.
        step(32'h0000_0400, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0);

        // Drain of bits 0, 2, 31 back to back.
        step(32'h8000_0005, 1'b0, 1'b1);
        repeat (4) step(32'h0, 1'b0, 1'b1);

        // Round robin ordering after re-assertion of a granted bit.
        step(32'h0000_0088, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b1);
        step(32'h0000_0008, 1'b0, 1'b0);
        repeat (3) step(32'h0, 1'b0, 1'b1);

        // Set-during-acknowledge collision on bit 5.
        step(32'h0000_0020, 1'b0, 1'b0);
        step(32'h0000_0020, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0);

        // Flush keeps only the requests of the flush cycle.
        step(32'h0000_00F0, 1'b0, 1'b0);
        step(32'h0000_0001, 1'b1, 1'b0);
        repeat (2) step(32'h0, 1'b0, 1'b1);

        // All 32 pending drain in 32 accepts.
        step(32'hFFFF_FFFF, 1'b0, 1'b1);
        repeat (33) step(32'h0, 1'b0, 1'b1);

        // Reset in the middle of a transfer.
        step(32'h0000_0003, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b1, 1'b1);
        step(32'h0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b1);

        for (int n = 0; n < 500; n++) begin
            logic [31:0] r;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 4)      r = 32'h0;
            else if (sel < 8) r = 32'd1 << $urandom_range(0, 31);
            else              r = $urandom & $urandom;
            step(r, ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7));
        end

        step(32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #3;
        check("scoreboard drained fixed", 32'(exp_q0.size()), 32'd0);
        check("scoreboard drained rr",    32'(exp_q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
